// File: rtl/decoder_pkg.sv
// Shared definitions for the scanned 3-to-8 decoder.
// State encoding, blank pattern and default dwell width.
package decoder_pkg;

    localparam int DEF_DWELL_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;

    localparam logic [7:0] BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        HOLD = ST_HOLD,
        SCAN = ST_SCAN
    } stateT;

endpackage

// File: rtl/dec38_comb.sv
// Combinational 3-to-8 decode, active-low enable,
// active-low one-cold select.
module dec38_comb
    import decoder_pkg::*;
(
    input  logic [2:0] code,
    input  logic       enN,
    output logic [7:0] sel
);

    always_comb begin
        sel = BLANK;
        if (!enN) sel[code] = 1'b0;
    end

endmodule

// File: rtl/decoder38_scan.sv
// Registered 3-to-8 decoder with direct handshake and auto-scan.
// Define DECODER_BLANK_EN for a blank cycle between scan slots.
module decoder38_scan
    import decoder_pkg::*;
#(
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iEI,
    input  logic               iMode,
    input  logic               iValid,
    output logic               oReady,
    input  logic [2:0]         iData,
    input  logic [DWELL_W-1:0] iDwell,
    output logic [7:0]         oData,
    output logic [2:0]         oCode,
    output logic               oWrap
);

    stateT              state, stateNext;
    logic [DWELL_W-1:0] cnt, cntNext;
    logic [2:0]         codeNext;
    logic               blank, blankNext;
    logic               wrapNext;
    logic               readyNext;
    logic               activeNext;
    logic [7:0]         selNext;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        codeNext  = oCode;
        blankNext = blank;
        wrapNext  = 1'b0;
        if (!iEI) begin
            unique case (state)
                IDLE: begin
                    if (oReady && iValid) begin
                        stateNext = HOLD;
                        codeNext  = iData;
                        cntNext   = iDwell;
                    end else if (iMode) begin
                        stateNext = SCAN;
                        codeNext  = 3'd0;
                        cntNext   = iDwell;
                        blankNext = 1'b0;
                    end
                end
                HOLD: begin
                    if (cnt == '0) stateNext = IDLE;
                    else cntNext = cnt - DWELL_W'(1);
                end
                SCAN: begin
`ifdef DECODER_BLANK_EN
                    if (blank) begin
                        blankNext = 1'b0;
                        cntNext   = iDwell;
                    end else if (cnt != '0) begin
                        cntNext = cnt - DWELL_W'(1);
                    end else if (!iMode) begin
                        stateNext = IDLE;
                    end else begin
                        // code advances during the blank gap
                        codeNext  = oCode + 3'd1;
                        blankNext = 1'b1;
                        wrapNext  = (oCode == 3'd7);
                    end
`else
                    if (cnt != '0) begin
                        cntNext = cnt - DWELL_W'(1);
                    end else if (!iMode) begin
                        stateNext = IDLE;
                    end else begin
                        codeNext = oCode + 3'd1;
                        cntNext  = iDwell;
                    end
`endif
                end
                default: stateNext = IDLE;
            endcase
        end
`ifndef DECODER_BLANK_EN
        // pulse lands on the final cycle of slot 7
        wrapNext = !iEI && stateNext == SCAN &&
                   codeNext == 3'd7 && cntNext == '0;
`endif
    end

    assign readyNext  = !iEI && stateNext == IDLE && !iMode;
    assign activeNext = !iEI &&
                        (stateNext == HOLD ||
                         (stateNext == SCAN && !blankNext));

    dec38_comb uDec (
        .code (codeNext),
        .enN  (!activeNext),
        .sel  (selNext)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state  <= IDLE;
            cnt    <= '0;
            oCode  <= 3'd0;
            blank  <= 1'b0;
            oData  <= BLANK;
            oReady <= 1'b0;
            oWrap  <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            oCode  <= codeNext;
            blank  <= blankNext;
            oData  <= selNext;
            oReady <= readyNext;
            oWrap  <= wrapNext;
        end
    end

endmodule

// File: tb/tb_decoder38_scan.sv
// Directed bench for decoder38_scan (default build, no blank gap).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_decoder38_scan;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iEI;
    logic       iMode;
    logic       iValid;
    logic       oReady;
    logic [2:0] iData;
    logic [7:0] iDwell;
    logic [7:0] oData;
    logic [2:0] oCode;
    logic       oWrap;

    int errors = 0;
    int checks = 0;

    decoder38_scan dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iEI    (iEI),
        .iMode  (iMode),
        .iValid (iValid),
        .oReady (oReady),
        .iData  (iData),
        .iDwell (iDwell),
        .oData  (oData),
        .oCode  (oCode),
        .oWrap  (oWrap)
    );

    always #5 iClk = ~iClk;

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        logic [7:0] one;
        iRst = 1'b1; iEI = 1'b0; iMode = 1'b0; iValid = 1'b0;
        iData = 3'd0; iDwell = 8'd0;

        // reset
        step(); step();
        chk("rst_data",  oData,  8'hFF);
        chk("rst_ready", {7'd0, oReady}, 8'd0);
        chk("rst_wrap",  {7'd0, oWrap},  8'd0);
        chk("rst_code",  {5'd0, oCode},  8'd0);
        iRst = 1'b0;
        step();
        chk("idle_ready", {7'd0, oReady}, 8'd1);
        chk("idle_data",  oData, 8'hFF);

        // direct transfer, dwell 2
        iDwell = 8'd2; iData = 3'd5; iValid = 1'b1;
        step();
        iValid = 1'b0;
        chk("hold5_c0", oData, 8'hDF);
        chk("hold5_rdy", {7'd0, oReady}, 8'd0);
        chk("hold5_code", {5'd0, oCode}, 8'd5);
        iValid = 1'b1; iData = 3'd2;
        step();
        chk("hold5_c1", oData, 8'hDF);
        step();
        chk("hold5_c2", oData, 8'hDF);
        chk("hold5_keep", {5'd0, oCode}, 8'd5);
        step();
        iValid = 1'b0;
        chk("hold5_end", oData, 8'hFF);
        chk("hold5_rdy2", {7'd0, oReady}, 8'd1);

        // reset during hold of code 6
        iDwell = 8'd3; iData = 3'd6; iValid = 1'b1;
        step();
        iValid = 1'b0;
        chk("hold6_c0", oData, 8'hBF);
        step();
        chk("hold6_c1", oData, 8'hBF);
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        chk("rst6_data", oData, 8'hFF);
        chk("rst6_rdy", {7'd0, oReady}, 8'd0);
        chk("rst6_code", {5'd0, oCode}, 8'd0);
        step();
        chk("rst6_idle", {7'd0, oReady}, 8'd1);

        // scan, dwell 0, two full sweeps
        iDwell = 8'd0; iMode = 1'b1;
        step();
        chk("scan_rdy", {7'd0, oReady}, 8'd0);
        for (int i = 0; i < 16; i++) begin
            one = 8'd1 << (i % 8);
            chk($sformatf("scan_d%0d", i), oData, ~one);
            chk($sformatf("scan_w%0d", i), {7'd0, oWrap},
                {7'd0, (i % 8) == 7});
            step();
        end
        chk("scan_again", oData, 8'hFE);

        // dwell 1 with a pause inside slot 2
        iDwell = 8'd1;
        step();
        chk("s1_c1a", oData, 8'hFD);
        step();
        chk("s1_c1b", oData, 8'hFD);
        step();
        chk("s1_c2a", oData, 8'hFB);
        iEI = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("pause%0d", i), oData, 8'hFF);
        end
        chk("pause_code", {5'd0, oCode}, 8'd2);
        chk("pause_rdy", {7'd0, oReady}, 8'd0);
        iEI = 1'b0;
        step();
        chk("resume_c2", oData, 8'hFB);
        step();
        chk("s1_c3a", oData, 8'hF7);
        step();
        chk("s1_c3b", oData, 8'hF7);
        step();
        chk("s1_c4a", oData, 8'hEF);

        // mode drops mid-slot with dwell 3
        iDwell = 8'd3;
        step();
        chk("s1_c4b", oData, 8'hEF);
        step();
        iMode = 1'b0;
        chk("m0_c0", oData, 8'hDF);
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("m0_c%0d", i), oData, 8'hDF);
        end
        step();
        chk("m0_idle", oData, 8'hFF);
        chk("m0_rdy", {7'd0, oReady}, 8'd1);

        // maximum dwell: 256 cycles of select
        iDwell = 8'hFF; iData = 3'd0; iValid = 1'b1;
        step();
        iValid = 1'b0;
        n = 0;
        while (oData == 8'hFE && n < 300) begin
            n++;
            step();
        end
        checks++;
        assert (n === 256) else begin
            errors++;
            $error("FAIL maxdwell: observed %0d expected 256", n);
        end
        chk("max_end", oData, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
